// File: rtl/de4_sopc_loader_pkg.sv
// rtl/de4_sopc_loader_pkg.sv - shared defaults, byte-enable constant and FSM states for the boot-memory loader
package de4_sopc_loader_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 32;

  localparam logic [DATA_W_DEF/8-1:0] BE_ALL = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/de4_sopc_loader_csum.sv
// rtl/de4_sopc_loader_csum.sv - clearable, enabled modulo-2**DATA_W running sum
module de4_sopc_loader_csum
  import de4_sopc_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/de4_sopc_onchip_memory_loader.sv
// rtl/de4_sopc_onchip_memory_loader.sv - streams boot words into on-chip memory, optional checksum read-back
module de4_sopc_onchip_memory_loader
  import de4_sopc_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       word_count,
  input  logic                  verify_en,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  verify_err,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam logic [DATA_W/8-1:0] be_on   = '1;
  localparam logic [ADDR_W:0]     rem_one = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     remaining;
  logic                verify_q;
  logic                rd_pend;
  logic                verr_q;
  logic [DATA_W-1:0]   wsum;
  logic [DATA_W-1:0]   rsum;

  logic accept;
  logic wr_cyc;
  logic rd_cyc;
  logic acc;

  assign accept = start && (state == S_IDLE);
  assign wr_cyc = (state == S_WRITE) && in_valid;
  assign rd_cyc = (state == S_READ);
  assign acc    = wr_cyc || rd_cyc;

  // Access strobes are decoded combinationally so WRITE sustains one word per cycle.
  assign in_ready       = (state == S_WRITE);
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);
  assign mem_chipselect = acc;
  assign mem_write      = wr_cyc;
  assign mem_address    = acc ? ptr : '0;
  assign mem_writedata  = wr_cyc ? in_data : '0;
  assign mem_byteenable = acc ? be_on : '0;
  assign mem_clken      = 1'b1;

  // rsum is final in DONE, so the compare is folded in there and made sticky at the same edge.
  assign verify_err = verr_q || ((state == S_DONE) && verify_q && (rsum != wsum));

  de4_sopc_loader_csum #(.DATA_W(DATA_W)) u_wsum (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (wr_cyc),
    .din   (in_data),
    .sum   (wsum)
  );

  de4_sopc_loader_csum #(.DATA_W(DATA_W)) u_rsum (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (rd_pend),
    .din   (mem_readdata),
    .sum   (rsum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      base_q    <= '0;
      count_q   <= '0;
      verify_q  <= 1'b0;
      ptr       <= '0;
      remaining <= '0;
      rd_pend   <= 1'b0;
      verr_q    <= 1'b0;
    end else begin
      rd_pend <= rd_cyc;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            count_q   <= word_count;
            verify_q  <= verify_en;
            ptr       <= base_addr;
            remaining <= word_count;
            verr_q    <= 1'b0;
            state     <= (word_count == '0) ? S_DONE : S_WRITE;
          end
        end
        S_WRITE: begin
          if (in_valid) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == rem_one) begin
              if (verify_q) begin
                ptr       <= base_q;
                remaining <= count_q;
                state     <= S_READ;
              end else begin
                state <= S_DONE;
              end
            end
          end
        end
        S_READ: begin
          ptr       <= ptr + 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == rem_one) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          state <= S_DONE;
        end
        S_DONE: begin
          if (verify_err) begin
            verr_q <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_de4_sopc_onchip_memory_loader.sv
// tb/tb_de4_sopc_onchip_memory_loader.sv - randomized jobs against a memory model and a per-cycle port model
module tb_de4_sopc_onchip_memory_loader;
  import de4_sopc_loader_pkg::*;

  localparam int AW    = 13;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [AW:0]     word_count = '0;
  logic            verify_en = 1'b0;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            in_ready, busy, done, verify_err;
  logic [AW-1:0]   mem_address;
  logic [DW/8-1:0] mem_byteenable;
  logic            mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0]   mem_writedata;
  logic [DW-1:0]   mem_readdata;

  logic [DW-1:0]   mem [DEPTH];
  logic            corrupt_req = 1'b0;
  logic [AW-1:0]   corrupt_addr = '0;

  int   n_checks = 0;
  int   n_pass = 0;
  logic prev_verr = 1'b0;

  always #5 clk = ~clk;

  de4_sopc_onchip_memory_loader dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .verify_en      (verify_en),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .busy           (busy),
    .done           (done),
    .verify_err     (verify_err),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  // Single-port slave: one-cycle read latency, junk on the bus when not reading.
  always @(posedge clk) begin
    if (mem_chipselect && mem_write) mem[mem_address] <= mem_writedata;
    if (corrupt_req) mem[corrupt_addr] <= mem[corrupt_addr] ^ 32'h1;
    mem_readdata <= (mem_chipselect && !mem_write) ? mem[mem_address] : 32'hdead_beef;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] pack(input logic rdy, input logic bsy, input logic dn,
                                       input logic ve, input logic cs, input logic wr,
                                       input logic ck, input logic [3:0] be,
                                       input logic [12:0] a, input logic [31:0] d);
    return {8'd0, rdy, bsy, dn, ve, cs, wr, ck, be, a, d};
  endfunction

  function automatic logic [63:0] ports();
    return pack(in_ready, busy, done, verify_err, mem_chipselect, mem_write, mem_clken,
                mem_byteenable, mem_address, mem_writedata);
  endfunction

  // mode: 0 full rate, 1 valid toggling, 2 random valid
  task automatic run_job(input string name, input int base, input int cnt, input bit ver,
                         input int mode, input bit corrupt, input bit mid_start, input int abort_at);
    logic [31:0] data [$];
    logic [31:0] wsum_exp = '0;
    logic [31:0] rsum_exp;
    logic [12:0] ea;
    logic        exp_verr;
    int          nxt = 0;
    int          last = -1;
    int          done_at;
    int          budget;
    bit          xfer, rd, seen_done = 0;

    for (int i = 0; i < cnt; i++) data.push_back((name == "seq") ? 32'(i + 1) : $urandom());
    done_at = (cnt == 0) ? 0 : -1;
    budget  = ((mode == 0) ? 3 * cnt : 8 * cnt) + 64;

    @(negedge clk);
    start = 1'b1; base_addr = 13'(base); word_count = 14'(cnt); verify_en = ver; in_valid = 1'b0;
    #1;
    check($sformatf("%s start", name), {59'd0, in_ready, busy, done, mem_chipselect, verify_err},
          {63'd0, prev_verr});

    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (mid_start && cyc == 2) begin
        start = 1'b1; base_addr = 13'($urandom()); word_count = 14'($urandom_range(1, 100)); verify_en = 1'b0;
      end
      if (abort_at == cyc) begin
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check($sformatf("%s reset", name), ports(), pack(0, 0, 0, 0, 0, 0, 1, 4'h0, 13'h0, 32'h0));
        for (int j = 0; j < 3; j++) begin
          @(negedge clk); #1;
          check($sformatf("%s quiet%0d", name, j), {61'd0, busy, done, mem_chipselect}, 64'd0);
        end
        prev_verr = 1'b0;
        return;
      end
      corrupt_req  = corrupt && (last >= 0) && (cyc == last + 1);
      corrupt_addr = 13'(base + cnt - 1);
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc[0] == 1'b0);
        default: in_valid = ($urandom_range(0, 99) < 60);
      endcase
      in_data = (nxt < cnt) ? data[nxt] : $urandom();
      #1;

      xfer = in_valid && (nxt < cnt);
      rd   = ver && (last >= 0) && (cyc > last) && (cyc <= last + cnt);
      ea   = xfer ? 13'(base + nxt) : (rd ? 13'(base + cyc - last - 1) : 13'h0);
      exp_verr = 1'b0;
      if (cyc == done_at) begin
        rsum_exp = corrupt ? (wsum_exp - data[cnt-1] + (data[cnt-1] ^ 32'h1)) : wsum_exp;
        exp_verr = ver && (rsum_exp != wsum_exp);
      end
      check($sformatf("%s c%0d", name, cyc), ports(),
            pack(nxt < cnt, 1'b1, cyc == done_at, exp_verr, xfer || rd, xfer, 1'b1,
                 (xfer || rd) ? BE_ALL : 4'h0, ea, xfer ? in_data : 32'h0));
      if (cyc == done_at) begin
        check($sformatf("%s wsum", name), 64'(dut.wsum), 64'(wsum_exp));
        prev_verr = exp_verr;
        seen_done = 1;
        break;
      end
      if (xfer) begin
        wsum_exp += in_data;
        nxt++;
        if (nxt == cnt) begin
          last    = cyc;
          done_at = ver ? cyc + cnt + 2 : cyc + 1;
        end
      end
    end
    corrupt_req = 1'b0;
    in_valid    = 1'b0;
    if (!seen_done) begin
      check($sformatf("%s done_timeout", name), 64'd0, 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      prev_verr = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", ports(), pack(0, 0, 0, 0, 0, 0, 1, 4'h0, 13'h0, 32'h0));
    @(negedge clk);
    reset = 1'b0;

    run_job("seq", 0, 4, 1'b1, 0, 1'b0, 1'b0, -1);
    run_job("wrap", 8190, 4, 1'b0, 0, 1'b0, 1'b0, -1);
    run_job("empty", $urandom_range(0, 8191), 0, 1'b1, 0, 1'b0, 1'b0, -1);
    run_job("full_corrupt", $urandom_range(0, 8191), 8192, 1'b1, 0, 1'b1, 1'b0, -1);
    run_job("toggle", $urandom_range(0, 8191), $urandom_range(10, 40), 1'b1, 1, 1'b0, 1'b1, -1);
    for (int k = 0; k < 4; k++)
      run_job($sformatf("rand%0d", k), $urandom_range(0, 8191), $urandom_range(1, 50),
              1'($urandom_range(0, 1)), 2, 1'b0, 1'b0, -1);
    run_job("abort", $urandom_range(0, 8191), 16, 1'b1, 0, 1'b0, 1'b0, 20);
    run_job("after_abort", 8185, 12, 1'b1, 2, 1'b0, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
